mul_issue_ctrl: RTL

Request/response controller directly upstream of the iterative multiplier (basemul). Accepts 32-bit multiply requests from execute and sign/zero-extends the operands to 33 bits. Issues them over basemul's in_valid/in_ready handshake and captures the single-cycle out_valid result pulse. Returns the selected 32-bit half under valid/ready backpressure, with flush and watchdog support; one operation is outstanding at a time.

---
 rtl/mul_pkg.sv | 23 ++
 rtl/mul_watchdog.sv | 41 ++++
 rtl/mul_issue_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiplier issue controller.
//   mul_state_e : controller FSM states
//   MUL_SRC_W   : width of the extended operands sent to basemul
//   MUL_RES_W   : width of the basemul product
//   ext33()     : sign/zero-extends a 32-bit operand to MUL_SRC_W bits
package mul_pkg;

  localparam int unsigned MUL_SRC_W = 33;
  localparam int unsigned MUL_RES_W = 64;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StDrain
  } mul_state_e;

  function automatic logic [MUL_SRC_W-1:0] ext33(input logic [31:0] x, input logic signed_en);
    return {signed_en & x[31], x};
  endfunction

endpackage

// File: rtl/mul_watchdog.sv
// Bounded cycle counter used to detect a multiplier that never answers.
//   clk, reset : clock and asynchronous active-high reset
//   clr_i      : restart the count from zero (takes priority over en_i)
//   en_i       : count this cycle
//   expired_o  : high during the TIMEOUT-th enabled cycle since the last clear
module mul_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_limit;

  assign at_limit  = (cnt_q >= CntW'(TIMEOUT - 1));
  assign expired_o = en_i && at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Request/response controller in front of the iterative multiplier (basemul).
// Accepts one 32-bit multiply request at a time, issues extended operands over
// the in_valid/in_ready handshake, captures the result pulse and returns the
// selected half under valid/ready backpressure.
//   req_*          : request port from execute (valid/ready)
//   mul_in_*, src* : issue port to basemul (valid/ready)
//   mul_out_valid, mul_result : single-cycle result pulse from basemul
//   rsp_*          : response port (valid/ready), data = selected half
//   flush          : cancel the in-flight operation
//   err_timeout, err_spurious : sticky error flags, cleared only by reset
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_x,
  input  logic [31:0]          req_y,
  input  logic                 req_signed,
  input  logic                 req_high,
  input  logic [TAG_W-1:0]     req_tag,
  output logic                 mul_in_valid,
  input  logic                 mul_in_ready,
  output logic [MUL_SRC_W-1:0] mul_src1,
  output logic [MUL_SRC_W-1:0] mul_src2,
  input  logic                 mul_out_valid,
  input  logic [MUL_RES_W-1:0] mul_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [MUL_RES_W-1:0] rsp_full,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 err_timeout,
  output logic                 err_spurious
);

  mul_state_e state_q, state_d;

  logic [MUL_SRC_W-1:0] src1_q, src1_d;
  logic [MUL_SRC_W-1:0] src2_q, src2_d;
  logic                 high_q, high_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [MUL_RES_W-1:0] res_q, res_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_spurious_q, err_spurious_d;

  logic accept;
  logic capture;
  logic set_timeout;
  logic wd_clr, wd_en, wd_expired;

  // Counter restarts on the issue handshake, even when it coincides with a
  // flush, so DRAIN gets a full timeout window.
  assign wd_clr = (state_q == StIssue) && mul_in_ready;
  assign wd_en  = (state_q == StWait) || (state_q == StDrain);

  mul_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    set_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        // Once in_ready is seen the multiplier owns the operation.
        if (mul_in_ready) begin
          state_d = flush ? StDrain : StWait;
        end else if (flush) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (flush) begin
          // A result arriving with the flush already ends the operation.
          state_d = mul_out_valid ? StIdle : StDrain;
        end else if (mul_out_valid) begin
          capture = 1'b1;
          state_d = StDone;
        end else if (wd_expired) begin
          set_timeout = 1'b1;
          state_d     = StIdle;
        end
      end
      StDone: begin
        if (flush) begin
          state_d = StIdle;
        end else if (rsp_ready) begin
          state_d = accept ? StIssue : StIdle;
        end
      end
      StDrain: begin
        if (mul_out_valid) begin
          state_d = StIdle;
        end else if (wd_expired) begin
          set_timeout = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready    = 1'b0;
    mul_in_valid = 1'b0;
    rsp_valid    = 1'b0;
    unique case (state_q)
      StIdle:  req_ready = 1'b1;
      StIssue: mul_in_valid = 1'b1;
      StDone: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready && !flush;
      end
      default: ;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Datapath and sticky error next-state
  always_comb begin
    src1_d         = src1_q;
    src2_d         = src2_q;
    high_d         = high_q;
    tag_d          = tag_q;
    res_d          = res_q;
    err_timeout_d  = err_timeout_q || set_timeout;
    err_spurious_d = err_spurious_q;
    if (accept) begin
      src1_d = ext33(req_y, req_signed);
      src2_d = ext33(req_x, req_signed);
      high_d = req_high;
      tag_d  = req_tag;
    end
    if (capture) begin
      res_d = mul_result;
    end
    if (mul_out_valid && !wd_en) begin
      err_spurious_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src1_q         <= '0;
      src2_q         <= '0;
      high_q         <= 1'b0;
      tag_q          <= '0;
      res_q          <= '0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      src1_q         <= src1_d;
      src2_q         <= src2_d;
      high_q         <= high_d;
      tag_q          <= tag_d;
      res_q          <= res_d;
      err_timeout_q  <= err_timeout_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  assign mul_src1     = src1_q;
  assign mul_src2     = src2_q;
  assign rsp_full     = res_q;
  assign rsp_data     = high_q ? res_q[63:32] : res_q[31:0];
  assign rsp_tag      = tag_q;
  assign err_timeout  = err_timeout_q;
  assign err_spurious = err_spurious_q;

endmodule
